// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_pkg
// Brief    : Shared types and encodings for the RV32I multicycle controller.
// Revision : 1.0
// ============================================================================
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_ILLEGAL  = 4'd10
  } state_t;

  localparam logic [6:0] c_OP_LW   = 7'b0000011;
  localparam logic [6:0] c_OP_SW   = 7'b0100011;
  localparam logic [6:0] c_OP_RALU = 7'b0110011;
  localparam logic [6:0] c_OP_IALU = 7'b0010011;
  localparam logic [6:0] c_OP_BEQ  = 7'b1100011;

  localparam logic [2:0] c_ALU_ADD = 3'b000;
  localparam logic [2:0] c_ALU_SUB = 3'b001;
  localparam logic [2:0] c_ALU_AND = 3'b010;
  localparam logic [2:0] c_ALU_OR  = 3'b011;
  localparam logic [2:0] c_ALU_SLT = 3'b101;

  // Coarse ALU intent from the FSM; the decoder refines c_ALUOP_FUNCT.
  localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] c_IMM_ZERO = 2'b00;
  localparam logic [1:0] c_IMM_I    = 2'b01;
  localparam logic [1:0] c_IMM_S    = 2'b10;
  localparam logic [1:0] c_IMM_B    = 2'b11;

  localparam logic [1:0] c_RES_ALUOUT = 2'b00;
  localparam logic [1:0] c_RES_MEM    = 2'b01;
  localparam logic [1:0] c_RES_ALU    = 2'b10;

  localparam logic [1:0] c_SRCA_PC    = 2'b00;
  localparam logic [1:0] c_SRCA_OLDPC = 2'b01;
  localparam logic [1:0] c_SRCA_RS1   = 2'b10;

  localparam logic [1:0] c_SRCB_RS2   = 2'b00;
  localparam logic [1:0] c_SRCB_IMM   = 2'b01;
  localparam logic [1:0] c_SRCB_FOUR  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mc_control_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_decoder
// Brief    : Maps FSM ALU intent plus funct fields to the ALU control code.
// Revision : 1.0
// ============================================================================
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = c_ALU_ADD;
    case (alu_op)
      c_ALUOP_SUB: alu_control = c_ALU_SUB;
      c_ALUOP_FUNCT: begin
        case (funct3)
          // funct7b5 only means sub for register-register ops, not addi.
          3'b000:  alu_control = (op5 & funct7b5) ? c_ALU_SUB : c_ALU_ADD;
          3'b010:  alu_control = c_ALU_SLT;
          3'b110:  alu_control = c_ALU_OR;
          3'b111:  alu_control = c_ALU_AND;
          default: alu_control = c_ALU_ADD;
        endcase
      end
      default: alu_control = c_ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
// Module   : mc_control
// Brief    : Multicycle RV32I control FSM driving the shared datapath.
// Revision : 1.0
// ============================================================================
module mc_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       illegal
);

  state_t     r_state;
  state_t     w_nextState;
  logic [1:0] w_aluOp;
  logic       w_pcWrite;
  logic       w_memWrite;
  logic       w_irWrite;
  logic       w_regWrite;
  logic       w_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_aluOp     = c_ALUOP_ADD;
    w_pcWrite   = 1'b0;
    w_memWrite  = 1'b0;
    w_irWrite   = 1'b0;
    w_regWrite  = 1'b0;
    w_illegal   = 1'b0;
    adr_src     = 1'b0;
    result_src  = c_RES_ALUOUT;
    alu_src_a   = c_SRCA_PC;
    alu_src_b   = c_SRCB_RS2;

    case (r_state)
      S_FETCH: begin
        alu_src_b  = c_SRCB_FOUR;
        result_src = c_RES_ALU;
        w_irWrite  = mem_ready;
        w_pcWrite  = mem_ready;
        if (mem_ready) w_nextState = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = c_SRCA_OLDPC;
        alu_src_b = c_SRCB_IMM;
        case (op)
          c_OP_LW, c_OP_SW: w_nextState = S_MEMADR;
          c_OP_RALU:        w_nextState = S_EXECR;
          c_OP_IALU:        w_nextState = S_EXECI;
          c_OP_BEQ:         w_nextState = S_BEQ;
          default:          w_nextState = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a   = c_SRCA_RS1;
        alu_src_b   = c_SRCB_IMM;
        w_nextState = (op == c_OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) w_nextState = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = c_RES_MEM;
        w_regWrite  = 1'b1;
        w_nextState = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        w_memWrite = 1'b1;
        if (mem_ready) w_nextState = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a   = c_SRCA_RS1;
        alu_src_b   = c_SRCB_RS2;
        w_aluOp     = c_ALUOP_FUNCT;
        w_nextState = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a   = c_SRCA_RS1;
        alu_src_b   = c_SRCB_IMM;
        w_aluOp     = c_ALUOP_FUNCT;
        w_nextState = S_ALUWB;
      end
      S_ALUWB: begin
        w_regWrite  = 1'b1;
        w_nextState = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a   = c_SRCA_RS1;
        alu_src_b   = c_SRCB_RS2;
        w_aluOp     = c_ALUOP_SUB;
        w_pcWrite   = zero;
        w_nextState = S_FETCH;
      end
      S_ILLEGAL: begin
        w_illegal   = 1'b1;
        w_nextState = S_ILLEGAL;
      end
      default: w_nextState = S_FETCH;
    endcase
  end

  // Reset masks every side effect immediately, even before the state flop clears.
  assign pc_write  = w_pcWrite  & ~rst;
  assign ir_write  = w_irWrite  & ~rst;
  assign mem_write = w_memWrite & ~rst;
  assign reg_write = w_regWrite & ~rst;
  assign illegal   = w_illegal  & ~rst;

  always_comb begin
    case (op)
      c_OP_LW, c_OP_IALU: imm_src = c_IMM_I;
      c_OP_SW:            imm_src = c_IMM_S;
      c_OP_BEQ:           imm_src = c_IMM_B;
      default:            imm_src = c_IMM_ZERO;
    endcase
  end

  alu_decoder u_aluDecoder (
    .alu_op      (w_aluOp),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control
// Brief    : Directed self-checking bench for the multicycle controller.
// Revision : 1.0
// ============================================================================
module tb_mc_control;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] imm_src;
  logic       reg_write;
  logic       illegal;

  int total = 0;
  int bad   = 0;

  mc_control dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .imm_src     (imm_src),
    .reg_write   (reg_write),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write, adr_src, mem_write, ir_write, result_src, src_a, src_b, alu_control, imm_src, reg_write, illegal}
  logic [16:0] obs;
  assign obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                alu_src_b, alu_control, imm_src, reg_write, illegal};

  function automatic logic [16:0] mk(logic pcw, logic adr, logic mw, logic irw,
                                     logic [1:0] rs, logic [1:0] sa, logic [1:0] sb,
                                     logic [2:0] ac, logic [1:0] is, logic rw, logic il);
    return {pcw, adr, mw, irw, rs, sa, sb, ac, is, rw, il};
  endfunction

  task automatic test_reset();
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_ready = (i == 0);
      #1;
      total++;
      if (obs !== mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b01,0,0)) begin
        $display("FAIL reset[%0d] got=%b want=%b", i, obs,
                 mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b01,0,0));
        bad++;
      end
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  task automatic test_lw();
    logic [16:0] e [5];
    e[0] = mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b01,0,0);
    e[1] = mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b01,0,0);
    e[2] = mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0,0);
    e[3] = mk(0,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b01,0,0);
    e[4] = mk(0,0,0,0,2'b01,2'b00,2'b00,3'b000,2'b01,1,0);
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b1;
      #1;
      total++;
      if (obs !== e[i]) begin
        $display("FAIL lw[%0d] got=%b want=%b", i, obs, e[i]);
        bad++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sw_stall();
    logic [16:0] e [7];
    logic        mr [7];
    e[0] = mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b10,0,0); mr[0] = 1'b0;
    e[1] = mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b10,0,0); mr[1] = 1'b1;
    e[2] = mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0,0); mr[2] = 1'b0;
    e[3] = mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b10,0,0); mr[3] = 1'b0;
    e[4] = mk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b10,0,0); mr[4] = 1'b0;
    e[5] = mk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b10,0,0); mr[5] = 1'b0;
    e[6] = mk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b10,0,0); mr[6] = 1'b1;
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr[i];
      #1;
      total++;
      if (obs !== e[i]) begin
        $display("FAIL sw[%0d] got=%b want=%b", i, obs, e[i]);
        bad++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_alu(input logic [6:0] opc, input logic [2:0] f3,
                          input logic f7, input logic [2:0] acExp);
    logic [16:0] e [4];
    logic [1:0]  imm;
    logic [1:0]  sb;
    imm = (opc == 7'b0010011) ? 2'b01 : 2'b00;
    sb  = (opc == 7'b0010011) ? 2'b01 : 2'b00;
    e[0] = mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,imm,0,0);
    e[1] = mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,imm,0,0);
    e[2] = mk(0,0,0,0,2'b00,2'b10,sb,acExp,imm,0,0);
    e[3] = mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,imm,1,0);
    op = opc; funct3 = f3; funct7b5 = f7;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      #1;
      total++;
      if (obs !== e[i]) begin
        $display("FAIL alu op=%b f3=%b f7=%b [%0d] got=%b want=%b", opc, f3, f7, i, obs, e[i]);
        bad++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_beq(input logic z);
    logic [16:0] e [3];
    e[0] = mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b11,0,0);
    e[1] = mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b11,0,0);
    e[2] = mk(z,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b11,0,0);
    op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0; zero = z;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1;
      #1;
      total++;
      if (obs !== e[i]) begin
        $display("FAIL beq z=%b [%0d] got=%b want=%b", z, i, obs, e[i]);
        bad++;
      end
      @(negedge clk);
    end
    zero = 1'b0;
  endtask

  task automatic test_illegal();
    logic [16:0] e;
    op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0;
    for (int i = 0; i < 14; i++) begin
      mem_ready = (i < 2) ? 1'b1 : logic'(i[0]);
      zero      = logic'(i[1]);
      if (i == 0)      e = mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0,0);
      else if (i == 1) e = mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0,0);
      else             e = mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,1);
      #1;
      total++;
      if (obs !== e) begin
        $display("FAIL illegal[%0d] got=%b want=%b", i, obs, e);
        bad++;
      end
      @(negedge clk);
    end
    zero = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if (obs !== mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0,0)) begin
      $display("FAIL illegal_rst got=%b want=%b", obs, mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));
      bad++;
    end
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    total++;
    if (obs !== mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0,0)) begin
      $display("FAIL illegal_fetch got=%b want=%b", obs, mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));
      bad++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_in_memwb();
    logic [16:0] e [5];
    e[0] = mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b01,0,0);
    e[1] = mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b01,0,0);
    e[2] = mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0,0);
    e[3] = mk(0,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b01,0,0);
    e[4] = mk(0,0,0,0,2'b01,2'b00,2'b00,3'b000,2'b01,1,0);
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b1;
      #1;
      total++;
      if (obs !== e[i]) begin
        $display("FAIL rstwb_pre[%0d] got=%b want=%b", i, obs, e[i]);
        bad++;
      end
      if (i < 4) @(negedge clk);
    end
    // Still inside MEMWB, before the rising edge.
    #1 rst = 1'b1;
    #1;
    total++;
    if (obs !== mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b01,0,0)) begin
      $display("FAIL rstwb_async got=%b want=%b", obs, mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b01,0,0));
      bad++;
    end
    @(negedge clk);
    #1;
    total++;
    if (obs !== mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b01,0,0)) begin
      $display("FAIL rstwb_hold got=%b want=%b", obs, mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b01,0,0));
      bad++;
    end
    rst = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (obs !== mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b01,0,0)) begin
        $display("FAIL rstwb_wait[%0d] got=%b want=%b", i, obs, mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b01,0,0));
        bad++;
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    total++;
    if (obs !== mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b01,0,0)) begin
      $display("FAIL rstwb_fetch got=%b want=%b", obs, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b01,0,0));
      bad++;
    end
    @(negedge clk);
    #1;
    total++;
    if (obs !== mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b01,0,0)) begin
      $display("FAIL rstwb_decode got=%b want=%b", obs, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b01,0,0));
      bad++;
    end
  endtask

  initial begin
    rst = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_lw();
    test_sw_stall();
    test_alu(7'b0110011, 3'b000, 1'b1, 3'b001);
    test_alu(7'b0110011, 3'b000, 1'b0, 3'b000);
    test_alu(7'b0010011, 3'b000, 1'b1, 3'b000);
    test_alu(7'b0110011, 3'b010, 1'b0, 3'b101);
    test_alu(7'b0110011, 3'b110, 1'b0, 3'b011);
    test_alu(7'b0010011, 3'b111, 1'b0, 3'b010);
    test_alu(7'b0110011, 3'b001, 1'b1, 3'b000);
    test_beq(1'b1);
    test_beq(1'b0);
    test_illegal();
    test_reset_in_memwb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_control.md
# mc_control

Multicycle control FSM for the RV32I core. Sequences the shared datapath (PC, instruction register, single memory port, register file, ALU, immediate extender) over several cycles per instruction. It drives every datapath select and write enable, including the extender's `imm_src`. It sits in the decode/control path, fed by the instruction register, and waits on the memory port through a ready handshake.

## Interface
Parameters: none.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- op  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory port completed access this cycle
- pc_write  out  1  PC load enable
- adr_src  out  1  memory address: 0=PC, 1=ALUOut
- mem_write  out  1  memory write request
- ir_write  out  1  IR and OldPC load enable
- result_src  out  2  00=ALUOut, 01=mem data, 10=ALU result
- alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1
- alu_src_b  out  2  00=rs2, 01=ImmExt, 10=const 4
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- imm_src  out  2  00=zero, 01=I, 10=S, 11=B
- reg_write  out  1  register file write enable
- illegal  out  1  unsupported opcode trapped

## Operation
- Supported opcodes: 0000011 lw, 0100011 sw, 0110011 R-ALU, 0010011 I-ALU, 1100011 beq. All others go to ILLEGAL.
- `imm_src` is combinational from `op` in all states: lw/I-ALU 01, sw 10, beq 11, else 00.
- States and outputs. Unlisted outputs are 0 / 00. ALU op is add unless stated.
  - FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10. ir_write=pc_write=mem_ready. Go to DECODE on mem_ready, else hold.
  - DECODE: alu_src_a=01, alu_src_b=01; branch target goes to ALUOut. Next state by op: lw/sw go to MEMADR, R-ALU to EXECR, I-ALU to EXECI, beq to BEQ, else ILLEGAL.
  - MEMADR: alu_src_a=10, alu_src_b=01. Next is MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: adr_src=1. Go to MEMWB on mem_ready, else hold.
  - MEMWB: result_src=01, reg_write=1. Next is FETCH.
  - MEMWRITE: adr_src=1, mem_write=1, held until mem_ready. Go to FETCH on mem_ready.
  - EXECR: alu_src_a=10, alu_src_b=00, ALU op from funct. Next is ALUWB.
  - EXECI: alu_src_a=10, alu_src_b=01, ALU op from funct. Next is ALUWB.
  - ALUWB: result_src=00, reg_write=1. Next is FETCH.
  - BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00, pc_write=zero. Next is FETCH.
  - ILLEGAL: illegal=1, all enables 0. Stays until reset.
- ALU decode from funct (funct3):
  - 000: sub if op[5]&funct7b5, else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Other funct3: add.

## Timing
- Reset: state=FETCH asynchronously.
- While rst=1, all enables (pc_write, ir_write, mem_write, reg_write) are forced to 0 and illegal=0. The select outputs take FETCH values.
- Transitions occur on the rising clk edge. Outputs are Moore, except pc_write/ir_write (FETCH, gated by mem_ready) and pc_write (BEQ, gated by zero).
- Cycle counts with mem_ready constantly 1: lw 5, sw 4, R/I 4, beq 3.
- Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle. No enable pulses more than once per instruction.
- mem_ready is ignored in all other states.
- Reset mid-instruction aborts it with no partial register-file or memory write after rst rises.

## Structure
- Package mc_pkg holds:
  - the state enum;
  - the opcode constants;
  - the alu_control codes;
  - the imm_src codes;
  - the result_src, alu_src_a and alu_src_b codes.
- One sub-module, alu_decoder: combinational, (alu_op[1:0], funct3, op5, funct7b5) → alu_control.
- The FSM and output decode live in mc_control.

## Test plan
- lw with mem_ready=1: FETCH→DECODE→MEMADR→MEMREAD→MEMWB→FETCH. One cycle each of ir_write, pc_write and reg_write, with result_src=01 in MEMWB. imm_src=01.
- sw with mem_ready low for 2 cycles in MEMWRITE: mem_write=1 for 3 cycles, adr_src=1, imm_src=10. Then FETCH; reg_write never asserts.
- R-type funct3=000 with funct7b5=1 gives alu_control=001 in EXECR. With funct7b5=0 it gives 000. For I-ALU (op=0010011) with funct7b5=1 it gives 000.
- beq: with zero=1, pc_write pulses in BEQ. With zero=0, no pc_write in BEQ. Both cases return to FETCH after 3 cycles. imm_src=11.
- op=1101111: DECODE→ILLEGAL. illegal=1 and all enables stay 0 for 10+ cycles; rst returns the FSM to FETCH.
- Assert rst in MEMWB before the edge: no reg_write after rst rises. State is FETCH immediately; after rst falls, FETCH waits for mem_ready.
